// File: rtl/uart_pkg.sv
// Shared UART word/byte widths and the byte-to-word reassembler state encoding.
// Declarations only; no latency or flow control.
package uart_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam int TMR_W  = 8;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_HI = 1'b1
  } b2w_state_t;

endpackage

// File: rtl/b2w_timeout.sv
// Inter-byte timer for byte_2_word; expire is combinational, count updates one edge later.
// No backpressure: advances only on ce cycles, holds otherwise.
module b2w_timeout
  import uart_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] count;

  assign expire = en && (count == LAST);

  // Restart from zero after expiring, so the count never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (ce) begin
      if (clr || expire) begin
        count <= '0;
      end else if (en) begin
        count <= count + 8'd1;
      end
    end
  end

endmodule

// File: rtl/byte_2_word.sv
// Pairs low/high bytes into 16-bit words; one register stage from high byte to word_dv.
// No backpressure: ce stalls everything; an orphaned low byte is dropped after TIMEOUT ce cycles.
module byte_2_word
  import uart_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              byte_dv,
  input  logic [BYTE_W-1:0] byteee,
  output logic              word_dv,
  output logic [WORD_W-1:0] word,
  output logic              err,
  output logic [7:0]        err_cnt
);

  b2w_state_t        state;
  logic [BYTE_W-1:0] low_reg;
  logic              tmr_clr;
  logic              tmr_en;
  logic              tmr_expire;

  assign tmr_clr = (state == IDLE) && byte_dv;
  assign tmr_en  = (state == WAIT_HI) && !byte_dv;

  b2w_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .expire(tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      low_reg <= '0;
      word    <= '0;
      word_dv <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (ce) begin
      word_dv <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (byte_dv) begin
            low_reg <= byteee;
            state   <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          // A high byte on the expiry cycle wins over the timeout.
          if (byte_dv) begin
            word    <= {byteee, low_reg};
            word_dv <= 1'b1;
            state   <= IDLE;
          end else if (tmr_expire) begin
            err     <= 1'b1;
            low_reg <= '0;
            state   <= IDLE;
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_2_word.sv
// Self-checking bench for byte_2_word with a short timeout so expiry paths are cheap to reach.
module tb_byte_2_word;
  import uart_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        byte_dv;
  logic [7:0]  byteee;
  logic        word_dv;
  logic [15:0] word;
  logic        err;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: a pending low byte and its age in ce cycles.
  logic        m_pend;
  logic [7:0]  m_low;
  int          m_age;
  logic [15:0] m_word;
  logic        m_dv;
  logic        m_err;
  int          m_cnt;

  always #5 clk = ~clk;

  byte_2_word #(
    .TIMEOUT(TO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .byte_dv(byte_dv),
    .byteee (byteee),
    .word_dv(word_dv),
    .word   (word),
    .err    (err),
    .err_cnt(err_cnt)
  );

  task automatic model_reset();
    m_pend = 1'b0;
    m_low  = '0;
    m_age  = 0;
    m_word = '0;
    m_dv   = 1'b0;
    m_err  = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic model_cycle(input logic c, input logic v, input logic [7:0] b);
    if (!c) return;
    m_dv  = 1'b0;
    m_err = 1'b0;
    if (v) begin
      if (m_pend) begin
        m_word = {b, m_low};
        m_dv   = 1'b1;
        m_pend = 1'b0;
      end else begin
        m_low  = b;
        m_pend = 1'b1;
        m_age  = 0;
      end
    end else if (m_pend) begin
      m_age++;
      if (m_age == TO) begin
        m_err  = 1'b1;
        m_pend = 1'b0;
        if (m_cnt < 255) m_cnt++;
      end
    end
  endtask

  task automatic step(input logic c, input logic v, input logic [7:0] b);
    @(negedge clk);
    rst     = 1'b0;
    ce      = c;
    byte_dv = v;
    byteee  = b;
    @(posedge clk);
    model_cycle(c, v, b);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    ce      = 1'($urandom);
    byte_dv = 1'($urandom);
    byteee  = 8'($urandom);
    @(posedge clk);
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({word_dv, err} !== 2'b00) begin
      n_err++; $display("FAIL reset_strobes: got dv=%b err=%b want 0 0", word_dv, err);
    end
    n_checks++;
    if (word !== 16'h0000) begin
      n_err++; $display("FAIL reset_word: got %h want 0000", word);
    end
    n_checks++;
    if (err_cnt !== 8'd0) begin
      n_err++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_pair();
    step(1, 1, 8'h34);
    n_checks++;
    if (word_dv !== 1'b0) begin
      n_err++; $display("FAIL pair_early_dv: got %b want 0", word_dv);
    end
    step(1, 1, 8'h12);
    n_checks++;
    if ({word_dv, word, err} !== {1'b1, 16'h1234, 1'b0}) begin
      n_err++; $display("FAIL pair_word: got dv=%b word=%h err=%b want 1 1234 0", word_dv, word, err);
    end
    step(1, 0, 8'h00);
    n_checks++;
    if ({word_dv, word} !== {1'b0, 16'h1234}) begin
      n_err++; $display("FAIL pair_hold: got dv=%b word=%h want 0 1234", word_dv, word);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    logic [15:0] exp;
    bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 4; i++) begin
      step(1, 1, bytes[i]);
      exp = (i == 1) ? 16'hBBAA : 16'hDDCC;
      n_checks++;
      if (i % 2 == 1) begin
        if ({word_dv, word} !== {1'b1, exp}) begin
          n_err++; $display("FAIL b2b_word%0d: got dv=%b word=%h want 1 %h", i, word_dv, word, exp);
        end
      end else if (word_dv !== 1'b0) begin
        n_err++; $display("FAIL b2b_gap%0d: got dv=%b want 0", i, word_dv);
      end
    end
  endtask

  task automatic test_ce_gap();
    step(1, 1, 8'h01);
    step(0, 1, 8'hEE);
    n_checks++;
    if (word_dv !== 1'b0) begin
      n_err++; $display("FAIL ce_spurious: got dv=%b want 0", word_dv);
    end
    step(1, 1, 8'h02);
    n_checks++;
    if ({word_dv, word} !== {1'b1, 16'h0201}) begin
      n_err++; $display("FAIL ce_word: got dv=%b word=%h want 1 0201", word_dv, word);
    end
    step(0, 0, 8'h00);
    n_checks++;
    if ({word_dv, word} !== {1'b1, 16'h0201}) begin
      n_err++; $display("FAIL ce_hold: got dv=%b word=%h want 1 0201", word_dv, word);
    end
    step(1, 0, 8'h00);
    n_checks++;
    if (word_dv !== 1'b0) begin
      n_err++; $display("FAIL ce_clear: got dv=%b want 0", word_dv);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step(1, 1, 8'h55);
    for (int i = 1; i <= TO; i++) begin
      step(1, 0, 8'h00);
      n_checks++;
      if (err !== (i == TO)) begin
        n_err++; $display("FAIL to_err_idle%0d: got %b want %b", i, err, (i == TO));
      end
    end
    n_checks++;
    if (err_cnt !== 8'd1) begin
      n_err++; $display("FAIL to_err_cnt: got %0d want 1", err_cnt);
    end
    step(1, 1, 8'h11);
    n_checks++;
    if ({err, word_dv} !== 2'b00) begin
      n_err++; $display("FAIL to_restart: got err=%b dv=%b want 0 0", err, word_dv);
    end
    step(1, 1, 8'h22);
    n_checks++;
    if ({word_dv, word} !== {1'b1, 16'h2211}) begin
      n_err++; $display("FAIL to_next_word: got dv=%b word=%h want 1 2211", word_dv, word);
    end
  endtask

  task automatic test_expiry_race();
    step(1, 1, 8'h55);
    for (int i = 0; i < TO - 1; i++) step(1, 0, 8'h00);
    step(1, 1, 8'h66);
    n_checks++;
    if ({word_dv, word, err} !== {1'b1, 16'h6655, 1'b0}) begin
      n_err++; $display("FAIL race_word: got dv=%b word=%h err=%b want 1 6655 0", word_dv, word, err);
    end
    step(1, 0, 8'h00);
    n_checks++;
    if ({err, err_cnt} !== {1'b0, 8'd1}) begin
      n_err++; $display("FAIL race_no_err: got err=%b cnt=%0d want 0 1", err, err_cnt);
    end
  endtask

  task automatic test_reset_mid_word();
    step(1, 1, 8'h77);
    do_reset();
    n_checks++;
    if ({err, word_dv, err_cnt} !== {2'b00, 8'd0}) begin
      n_err++; $display("FAIL rstmid_outputs: got err=%b dv=%b cnt=%0d want 0 0 0", err, word_dv, err_cnt);
    end
    step(1, 1, 8'h88);
    step(1, 1, 8'h99);
    n_checks++;
    if ({word_dv, word, err_cnt} !== {1'b1, 16'h9988, 8'd0}) begin
      n_err++; $display("FAIL rstmid_word: got dv=%b word=%h cnt=%0d want 1 9988 0", word_dv, word, err_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 1; k <= 256; k++) begin
      step(1, 1, 8'($urandom));
      for (int i = 0; i < TO; i++) step(1, 0, 8'h00);
      if (k >= 254) begin
        n_checks++;
        if ({err, err_cnt} !== {1'b1, 8'(m_cnt)}) begin
          n_err++; $display("FAIL sat_cnt%0d: got err=%b cnt=%0d want 1 %0d", k, err, err_cnt, m_cnt);
        end
      end
    end
    n_checks++;
    if (err_cnt !== 8'hFF) begin
      n_err++; $display("FAIL sat_final: got %0d want 255", err_cnt);
    end
  endtask

  task automatic test_random();
    logic c, v;
    int pct;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      pct = ((i / 100) % 2 == 0) ? 60 : 12;
      c = ($urandom_range(0, 99) < 75);
      v = ($urandom_range(0, 99) < pct);
      step(c, v, 8'($urandom));
      n_checks++;
      if ({word_dv, word, err, err_cnt} !== {m_dv, m_word, m_err, 8'(m_cnt)}) begin
        n_err++;
        $display("FAIL rand_cycle%0d: got dv=%b word=%h err=%b cnt=%0d want %b %h %b %0d",
                 i, word_dv, word, err, err_cnt, m_dv, m_word, m_err, m_cnt);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    ce      = 1'b0;
    byte_dv = 1'b0;
    byteee  = '0;
    model_reset();
    test_reset();
    test_pair();
    test_back_to_back();
    test_ce_gap();
    test_timeout();
    test_expiry_race();
    test_reset_mid_word();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
